// File: rtl/pc_sequencer.sv
// RISC-V program-counter sequencer: fetch/retire handshake FSM, shared branch-target adder.
// Optional macro PC_MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VECTOR and reports them.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetchReady,
    input  logic        instrDone,
    input  logic [1:0]  pcSrc,
    input  logic [31:0] immExt,
    input  logic [31:0] aluResult,
    input  logic        halt,
    output logic [31:0] pc,
    output logic        fetchValid,
    output logic [31:0] pcPlus4,
    output logic [31:0] pcTarget,
    output logic        halted,
    output logic        trap,
    output logic [31:0] trapAddr,
    output logic [31:0] retiredCount
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;

    state_t      state;
    logic [31:0] selTarget;
    logic [31:0] nextPc;
    logic        misaligned;

    assign pcPlus4    = pc + 32'd4;
    assign pcTarget   = pc + immExt;
    assign fetchValid = (state == FETCH);
    assign halted     = (state == HALT);

    always_comb begin
        selTarget = pcPlus4;
        case (pcSrc)
            2'b01:   selTarget = pcTarget;
            2'b10:   selTarget = {aluResult[31:1], 1'b0};
            default: selTarget = pcPlus4;
        endcase
    end

    assign misaligned = |selTarget[1:0];

`ifdef PC_MISALIGN_TRAP_EN
    assign nextPc = misaligned ? TRAP_VECTOR : selTarget;
`else
    assign nextPc   = {selTarget[31:2], 2'b00};
    assign trap     = 1'b0;
    assign trapAddr = 32'h0;

    // Trap vector and the misalignment flag have no consumer in this build.
    logic unusedTrapPath;
    assign unusedTrapPath = ^{TRAP_VECTOR, misaligned};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc           <= RESET_VECTOR;
            state        <= IDLE;
            retiredCount <= 32'h0;
`ifdef PC_MISALIGN_TRAP_EN
            trap         <= 1'b0;
            trapAddr     <= 32'h0;
`endif
        end else begin
`ifdef PC_MISALIGN_TRAP_EN
            trap <= 1'b0;
`endif
            case (state)
                IDLE:  state <= FETCH;
                FETCH: if (fetchReady) state <= EXEC;
                EXEC: begin
                    if (instrDone) begin
                        pc           <= nextPc;
                        retiredCount <= retiredCount + 32'd1;
                        state        <= halt ? HALT : FETCH;
`ifdef PC_MISALIGN_TRAP_EN
                        if (misaligned) begin
                            trap     <= 1'b1;
                            trapAddr <= selTarget;
                        end
`endif
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed test-plan scenarios plus randomized handshakes
// checked against an instruction-level reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetchReady = 1'b0;
    logic        instrDone = 1'b0;
    logic        halt = 1'b0;
    logic [1:0]  pcSrc = 2'b00;
    logic [31:0] immExt = 32'h0;
    logic [31:0] aluResult = 32'h0;
    logic [31:0] pc, pcPlus4, pcTarget, trapAddr, retiredCount;
    logic        fetchValid, halted, trap;

    int checks = 0;
    int errors = 0;

    // Reference model state: architectural PC, retire count, last trap address.
    logic [31:0] mPc = 32'h0;
    logic [31:0] mRet = 32'h0;
    logic [31:0] mTrapAddr = 32'h0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .fetchReady(fetchReady), .instrDone(instrDone),
        .pcSrc(pcSrc), .immExt(immExt), .aluResult(aluResult), .halt(halt),
        .pc(pc), .fetchValid(fetchValid), .pcPlus4(pcPlus4), .pcTarget(pcTarget),
        .halted(halted), .trap(trap), .trapAddr(trapAddr), .retiredCount(retiredCount)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, want finish before 500000");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic void refNext(input logic [31:0] curPc, input logic [1:0] src,
                                    input logic [31:0] imm, input logic [31:0] alu,
                                    output logic [31:0] nxt, output bit mis,
                                    output logic [31:0] raw);
        case (src)
            2'd1:    raw = curPc + imm;
            2'd2:    raw = alu - (alu % 2);
            default: raw = curPc + 32'd4;
        endcase
        mis = (raw % 4) != 0;
`ifdef PC_MISALIGN_TRAP_EN
        nxt = mis ? 32'h0000_0100 : raw;
`else
        nxt = raw - (raw % 4);
`endif
    endfunction

    task automatic doReset;
        reset = 1'b1;
        fetchReady = 1'($urandom);
        instrDone = 1'b1;
        step;
        step;
        reset = 1'b0;
        fetchReady = 1'b0;
        instrDone = 1'b0;
        halt = 1'b0;
        mPc = 32'h0;
        mRet = 32'h0;
        mTrapAddr = 32'h0;
    endtask

    // One full instruction: fetch (with stalls), exec (with stalls), retire.
    task automatic doInstr(input logic [1:0] src, input logic [31:0] imm, input logic [31:0] alu,
                           input logic hlt, input int fStall, input int eStall);
        int waitCnt = 0;
        logic [31:0] raw, nxt;
        bit mis;
        logic expTrap;
        logic [31:0] expTrapAddr;
        while (fetchValid !== 1'b1 && waitCnt < 4) begin
            step;
            waitCnt++;
        end
        checks++;
        if (fetchValid !== 1'b1) begin
            errors++;
            $display("FAIL fetch_timeout fetchValid=%b want 1", fetchValid);
            return;
        end
        checks++;
        if (pc !== mPc) begin
            errors++;
            $display("FAIL fetch_pc pc=%h want %h", pc, mPc);
        end
        for (int i = 0; i < fStall; i++) begin
            fetchReady = 1'b0;
            instrDone = 1'($urandom);
            halt = 1'($urandom);
            step;
            checks++;
            if (fetchValid !== 1'b1 || pc !== mPc) begin
                errors++;
                $display("FAIL fetch_stall fetchValid=%b pc=%h want 1 %h", fetchValid, pc, mPc);
            end
        end
        fetchReady = 1'b1;
        instrDone = 1'b0;
        halt = 1'b0;
        step;
        checks++;
        if (fetchValid !== 1'b0 || pc !== mPc || halted !== 1'b0) begin
            errors++;
            $display("FAIL exec_entry fetchValid=%b pc=%h halted=%b want 0 %h 0",
                     fetchValid, pc, halted, mPc);
        end
        for (int i = 0; i < eStall; i++) begin
            instrDone = 1'b0;
            halt = 1'($urandom);
            fetchReady = 1'($urandom);
            step;
            checks++;
            if (fetchValid !== 1'b0 || pc !== mPc || retiredCount !== mRet) begin
                errors++;
                $display("FAIL exec_wait fetchValid=%b pc=%h ret=%0d want 0 %h %0d",
                         fetchValid, pc, retiredCount, mPc, mRet);
            end
        end
        pcSrc = src;
        immExt = imm;
        aluResult = alu;
        halt = hlt;
        fetchReady = 1'b0;
        instrDone = 1'b1;
        #1;
        checks++;
        if (pcPlus4 !== mPc + 32'd4 || pcTarget !== mPc + imm) begin
            errors++;
            $display("FAIL adders pcPlus4=%h pcTarget=%h want %h %h",
                     pcPlus4, pcTarget, mPc + 32'd4, mPc + imm);
        end
        refNext(mPc, src, imm, alu, nxt, mis, raw);
        step;
        instrDone = 1'b0;
        halt = 1'b0;
        mPc = nxt;
        mRet = mRet + 32'd1;
`ifdef PC_MISALIGN_TRAP_EN
        if (mis) mTrapAddr = raw;
        expTrap = mis;
        expTrapAddr = mTrapAddr;
`else
        expTrap = 1'b0;
        expTrapAddr = 32'h0;
`endif
        checks++;
        if (pc !== mPc) begin
            errors++;
            $display("FAIL next_pc pc=%h want %h (src=%0d)", pc, mPc, src);
        end
        checks++;
        if (retiredCount !== mRet) begin
            errors++;
            $display("FAIL retired retiredCount=%0d want %0d", retiredCount, mRet);
        end
        checks++;
        if (halted !== hlt || fetchValid !== !hlt) begin
            errors++;
            $display("FAIL post_retire halted=%b fetchValid=%b want %b %b",
                     halted, fetchValid, hlt, !hlt);
        end
        checks++;
        if (trap !== expTrap || trapAddr !== expTrapAddr) begin
            errors++;
            $display("FAIL trap trap=%b trapAddr=%h want %b %h", trap, trapAddr, expTrap, expTrapAddr);
        end
        step;
        checks++;
        if (trap !== 1'b0 || trapAddr !== expTrapAddr) begin
            errors++;
            $display("FAIL trap_pulse trap=%b trapAddr=%h want 0 %h", trap, trapAddr, expTrapAddr);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        fetchReady = 1'b1;
        instrDone = 1'b1;
        halt = 1'b1;
        step;
        step;
        checks++;
        if (pc !== 32'h0 || retiredCount !== 32'h0) begin
            errors++;
            $display("FAIL reset_pc pc=%h ret=%0d want 0 0", pc, retiredCount);
        end
        checks++;
        if (fetchValid !== 1'b0 || halted !== 1'b0 || trap !== 1'b0 || trapAddr !== 32'h0) begin
            errors++;
            $display("FAIL reset_flags fv=%b halted=%b trap=%b trapAddr=%h want 0 0 0 0",
                     fetchValid, halted, trap, trapAddr);
        end
        reset = 1'b0;
        halt = 1'b0;
        checks++;
        if (fetchValid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle fetchValid=%b want 0", fetchValid);
        end
        step;
        checks++;
        if (fetchValid !== 1'b1 || pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_fetch fetchValid=%b pc=%h want 1 0", fetchValid, pc);
        end
    endtask

    task automatic test_sequential;
        doReset;
        fetchReady = 1'b1;
        instrDone = 1'b1;
        pcSrc = 2'b00;
        for (int k = 0; k < 4; k++) begin
            step;
            checks++;
            if (fetchValid !== 1'b1 || pc !== 32'(4 * k) || retiredCount !== 32'(k)) begin
                errors++;
                $display("FAIL seq_fetch fv=%b pc=%h ret=%0d want 1 %h %0d",
                         fetchValid, pc, retiredCount, 32'(4 * k), k);
            end
            if (k == 3) break;
            step;
            checks++;
            if (fetchValid !== 1'b0 || pc !== 32'(4 * k)) begin
                errors++;
                $display("FAIL seq_exec fv=%b pc=%h want 0 %h", fetchValid, pc, 32'(4 * k));
            end
        end
        fetchReady = 1'b0;
        instrDone = 1'b0;
        mPc = 32'hC;
        mRet = 32'd3;
    endtask

    task automatic test_branch;
        doReset;
        doInstr(2'b00, 32'h0, 32'h0, 1'b0, 0, 0);
        doInstr(2'b01, 32'h4, 32'h0, 1'b0, 0, 0);
        checks++;
        if (pc !== 32'h8) begin
            errors++;
            $display("FAIL branch_aligned pc=%h want 00000008", pc);
        end
        doInstr(2'b00, 32'h0, 32'h0, 1'b0, 0, 0);
        doInstr(2'b01, 32'hA, 32'h0, 1'b0, 0, 0);
        checks++;
`ifdef PC_MISALIGN_TRAP_EN
        if (pc !== 32'h100 || trapAddr !== 32'h16) begin
            errors++;
            $display("FAIL branch_misaligned pc=%h trapAddr=%h want 00000100 00000016", pc, trapAddr);
        end
`else
        if (pc !== 32'h14 || trapAddr !== 32'h0) begin
            errors++;
            $display("FAIL branch_misaligned pc=%h trapAddr=%h want 00000014 0", pc, trapAddr);
        end
`endif
    endtask

    task automatic test_fetch_stall;
        doInstr(2'b00, 32'h0, 32'h0, 1'b0, 3, 2);
    endtask

    task automatic test_jalr_wrap;
        doInstr(2'b10, 32'h0, 32'h2001, 1'b0, 0, 0);
        checks++;
        if (pc !== 32'h2000 || trap !== 1'b0) begin
            errors++;
            $display("FAIL jalr pc=%h trap=%b want 00002000 0", pc, trap);
        end
        doInstr(2'b10, 32'h0, 32'hFFFF_FFFD, 1'b0, 1, 1);
        doInstr(2'b00, 32'h0, 32'h0, 1'b0, 0, 0);
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap pc=%h want 00000000", pc);
        end
        doInstr(2'b10, 32'h0, 32'h11, 1'b0, 0, 0);
        doInstr(2'b01, 32'hFFFF_FFF8, 32'h0, 1'b0, 0, 0);
        checks++;
        if (pc !== 32'h8) begin
            errors++;
            $display("FAIL negative_offset pc=%h want 00000008", pc);
        end
    endtask

    task automatic test_halt;
        doReset;
        doInstr(2'b10, 32'h0, 32'h8, 1'b0, 0, 0);
        doInstr(2'b00, 32'h0, 32'h0, 1'b1, 0, 1);
        for (int i = 0; i < 6; i++) begin
            fetchReady = 1'($urandom);
            instrDone = 1'($urandom);
            halt = 1'($urandom);
            step;
            checks++;
            if (fetchValid !== 1'b0 || halted !== 1'b1 || pc !== 32'hC || retiredCount !== mRet) begin
                errors++;
                $display("FAIL halt_hold fv=%b halted=%b pc=%h ret=%0d want 0 1 0000000c %0d",
                         fetchValid, halted, pc, retiredCount, mRet);
            end
        end
        doReset;
        checks++;
        if (pc !== 32'h0 || retiredCount !== 32'h0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset pc=%h ret=%0d halted=%b want 0 0 0", pc, retiredCount, halted);
        end
    endtask

    task automatic test_exec_reset;
        int waitCnt = 0;
        doReset;
        doInstr(2'b00, 32'h0, 32'h0, 1'b0, 0, 0);
        doInstr(2'b00, 32'h0, 32'h0, 1'b0, 0, 0);
        while (fetchValid !== 1'b1 && waitCnt < 4) begin
            step;
            waitCnt++;
        end
        fetchReady = 1'b1;
        step;
        fetchReady = 1'b0;
        pcSrc = 2'b01;
        immExt = 32'h40;
        instrDone = 1'b1;
        reset = 1'b1;
        step;
        reset = 1'b0;
        instrDone = 1'b0;
        checks++;
        if (pc !== 32'h0 || retiredCount !== 32'h0 || fetchValid !== 1'b0) begin
            errors++;
            $display("FAIL exec_reset pc=%h ret=%0d fv=%b want 0 0 0", pc, retiredCount, fetchValid);
        end
        step;
        checks++;
        if (fetchValid !== 1'b1) begin
            errors++;
            $display("FAIL exec_reset_restart fetchValid=%b want 1", fetchValid);
        end
        mPc = 32'h0;
        mRet = 32'h0;
        mTrapAddr = 32'h0;
    endtask

    task automatic test_random;
        logic [31:0] imm;
        for (int n = 0; n < 40; n++) begin
            imm = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 63)) - 32'd32;
            doInstr(2'($urandom), imm, 32'($urandom), 1'b0,
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset;
        test_sequential;
        test_branch;
        test_fetch_stall;
        test_jalr_wrap;
        test_halt;
        test_exec_reset;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Sequences the program counter for the RISC-V core.
- Owns the PC register and shares the branch-target adder (pc + immExt) between branch and jal.
- Also handles jalr redirects and sequential fetch.
- Runs an instruction-memory fetch handshake and a retire handshake, so fetch and execute may take multiple cycles when memory stalls.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- TRAP_VECTOR, 32'h0000_0100, redirect address for misaligned targets (only used with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- pc  output  32  current PC / fetch address.
- fetchValid  output  1  fetch request to instruction memory.
- fetchReady  input  1  instruction memory accepted the fetch; instruction is available this cycle.
- instrDone  input  1  core has finished executing the fetched instruction; next-PC inputs are valid this cycle.
- pcSrc  input  2  next-PC select: 00 = pc+4, 01 = pcTarget, 10 = jalr, 11 = reserved (treated as 00).
- immExt  input  32  sign-extended immediate for branch/jal.
- aluResult  input  32  jalr target (rs1 + imm).
- halt  input  1  stop sequencing after the current instruction.
- pcPlus4  output  32  pc + 4, combinational, used as link value.
- pcTarget  output  32  pc + immExt, combinational.
- halted  output  1  high in HALT state.
- trap  output  1  one-cycle pulse on misaligned redirect.
- trapAddr  output  32  last offending target address.
- retiredCount  output  32  number of retired instructions.

Behaviour:
- States: IDLE, FETCH, EXEC, HALT.
- Reset (any state, any cycle, overrides everything):
  - pc = RESET_VECTOR, state = IDLE, retiredCount = 0.
  - trap = 0, trapAddr = 0, fetchValid = 0, halted = 0.
- IDLE: go to FETCH unconditionally on the next cycle. Gives exactly one cycle of fetchValid=0 after reset.
- FETCH:
  - fetchValid = 1 (combinational, based on state).
  - pc is held stable while fetchValid is high; fetchValid never drops before fetchReady.
  - On fetchReady = 1, go to EXEC.
  - instrDone is ignored in FETCH.
- EXEC:
  - fetchValid = 0; wait for instrDone.
  - On instrDone: register the next PC, increment retiredCount by 1 (wraps at 2^32).
  - Then go to HALT if halt = 1 that same cycle, otherwise FETCH.
  - halt without instrDone has no effect.
- HALT:
  - halted = 1, fetchValid = 0, pc frozen.
  - Exits only on reset.
- Next-PC selection:
  - 00 / 11: pc + 4.
  - 01: pcTarget.
  - 10: {aluResult[31:1], 1'b0}.
- Arithmetic: all additions are 32-bit modulo 2^32. pc = 32'hFFFF_FFFC with pc+4 wraps to 0. Negative immExt subtracts through two's complement.
- Misaligned target: the selected next PC has bits[1:0] != 0; handling is defined by the optional feature below.
- Latency: the new pc is visible the cycle after instrDone. A fetch is issued in the following cycle (FETCH state). Minimum 2 cycles per instruction when fetchReady and instrDone are always high.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned next PC loads TRAP_VECTOR instead.
  - trap pulses high for exactly one cycle (the cycle after instrDone).
  - trapAddr captures the offending unmasked target; trapAddr holds until the next trap or reset.
  - retiredCount still increments.
- Undefined:
  - Next PC is the target with bits[1:0] forced to 00.
  - trap tied to 0; trapAddr tied to 0.

Test Plan:
- Reset with fetchReady and instrDone held high, pcSrc = 00: pc sequence 0x0, 0x4, 0x8, 0xC (a new pc every 2 cycles); fetchValid low for 1 cycle after reset; retiredCount = 3 after the third retire.
- Branch at pc = 0x4 with immExt = 0x4, pcSrc = 01: pcTarget = 0x8, next pc = 0x8. At pc = 0xC with immExt = 0xA, pcSrc = 01: pcTarget = 0x16; with the macro: pc = 0x100, trap pulse, trapAddr = 0x16; without the macro: pc = 0x14.
- Fetch stall, fetchReady low for 3 cycles: fetchValid stays high and pc constant for all 3 cycles; EXEC is entered only in the cycle after fetchReady rises.
- jalr with aluResult = 0x2001, pcSrc = 10: next pc = 0x2000, no trap. Wrap check: pc = 0xFFFFFFFC with pcSrc = 00 gives next pc = 0x0. Negative offset: pc = 0x10 with immExt = 0xFFFFFFF8 gives pcTarget = 0x8.
- halt and instrDone in the same cycle at pc = 0x8 with pcSrc = 00: pc becomes 0xC, halted = 1, fetchValid stays 0 indefinitely; a later reset returns pc to 0x0 and clears retiredCount.
- Reset asserted in EXEC mid-instruction with instrDone also high: pc = RESET_VECTOR, retiredCount does not increment, state restarts at IDLE.
